// File: rtl/decider_param.sv
// rtl/decider_param.sv - parametrised keypad lock controller; optional idle timeout under DECIDER_IDLE_TIMEOUT_EN
module decider_param #(
  parameter int                    N_DIGITS    = 4,
  parameter logic [4*N_DIGITS-1:0] DEFAULT_KEY = 16'h1234,
  parameter int                    MAX_FAIL    = 3,
  parameter int                    OPEN_CYC    = 500,
  parameter int                    LOCKOUT_CYC = 1000,
  parameter int                    TIMEOUT_CYC = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Code_1,
  input  logic       Valid_1,
  output logic       OPEN,
  output logic       LOCK,
  output logic       SAVE_LIGHT,
  output logic       ALARM,
  output logic       ERR,
  output logic [3:0] fail_cnt,
  output logic [3:0] count_1
);

  localparam int KW      = 4 * N_DIGITS;
  localparam int MAX_AB  = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Timers count down from CYC-1 so the state is held for exactly CYC cycles
  localparam logic [TW-1:0] OPEN_LD  = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LOCK_LD  = TW'(LOCKOUT_CYC - 1);
  localparam logic [3:0]    CNT_FULL = 4'(N_DIGITS);
  localparam logic [3:0]    CNT_OVF  = 4'(N_DIGITS + 1);
  localparam logic [3:0]    FAIL_MAX = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_LOCKED    = 3'd0,
    S_OPEN      = 3'd1,
    S_SAVE_NEW  = 3'd2,
    S_SAVE_CONF = 3'd3,
    S_LOCKOUT   = 3'd4
  } state_t;

  state_t          state_q, state_n;
  logic [KW-1:0]   key_q, temp_q, buf_q;
  logic [3:0]      cnt_q, fail_q;
  logic [TW-1:0]   tmr_q;
  logic            err_q;

  logic            is_digit, is_star, is_hash;
  logic            full, key_match, conf_match, tmr_zero, fail_last, idle_exp;
  logic            clr_entry, shift_digit, load_temp, commit_key;
  logic            fail_inc, fail_clr, err_n, tmr_ld;
  logic [TW-1:0]   tmr_val;

  assign is_digit   = Valid_1 && (Code_1 <= 4'd9);
  assign is_star    = Valid_1 && (Code_1 == 4'hA);
  assign is_hash    = Valid_1 && (Code_1 == 4'hB);
  assign full       = (cnt_q == CNT_FULL);
  assign key_match  = full && (buf_q == key_q);
  assign conf_match = full && (buf_q == temp_q);
  assign tmr_zero   = (tmr_q == '0);
  assign fail_last  = (fail_q >= (FAIL_MAX - 4'd1));

`ifdef DECIDER_IDLE_TIMEOUT_EN
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] idle_q;
  logic          idle_state;

  assign idle_state = (state_q == S_LOCKED) || (state_q == S_SAVE_NEW) || (state_q == S_SAVE_CONF);
  assign idle_exp   = idle_state && !Valid_1 && (idle_q == IDLE_LAST);

  // Count consecutive cycles without key activity while an entry can be in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 idle_q <= '0;
    else if (!idle_state || Valid_1 || idle_exp)  idle_q <= '0;
    else                                          idle_q <= idle_q + TW'(1);
  end
`else
  assign idle_exp = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_LOCKED;
    else          state_q <= state_n;
  end

  // Next-state and datapath control; timer expiry is tested before any key
  always_comb begin
    state_n     = state_q;
    clr_entry   = 1'b0;
    shift_digit = 1'b0;
    load_temp   = 1'b0;
    commit_key  = 1'b0;
    fail_inc    = 1'b0;
    fail_clr    = 1'b0;
    err_n       = 1'b0;
    tmr_ld      = 1'b0;
    tmr_val     = '0;
    case (state_q)
      S_LOCKED: begin
        if (idle_exp) begin
          clr_entry = 1'b1;
        end else if (is_digit) begin
          shift_digit = 1'b1;
        end else if (is_hash || is_star) begin
          clr_entry = 1'b1;
          if (key_match) begin
            if (is_hash) begin
              state_n  = S_OPEN;
              fail_clr = 1'b1;
              tmr_ld   = 1'b1;
              tmr_val  = OPEN_LD;
            end else begin
              state_n = S_SAVE_NEW;
            end
          end else begin
            err_n    = 1'b1;
            fail_inc = 1'b1;
            if (fail_last) begin
              state_n = S_LOCKOUT;
              tmr_ld  = 1'b1;
              tmr_val = LOCK_LD;
            end
          end
        end
      end
      S_OPEN: begin
        if (tmr_zero) begin
          state_n   = S_LOCKED;
          clr_entry = 1'b1;
        end else if (is_hash) begin
          clr_entry = 1'b1;
          tmr_ld    = 1'b1;
          tmr_val   = OPEN_LD;
        end else if (is_star) begin
          clr_entry = 1'b1;
          state_n   = S_LOCKED;
        end
      end
      S_SAVE_NEW, S_SAVE_CONF: begin
        if (idle_exp) begin
          clr_entry = 1'b1;
          err_n     = 1'b1;
          state_n   = S_LOCKED;
        end else if (is_digit) begin
          shift_digit = 1'b1;
        end else if (is_hash) begin
          clr_entry = 1'b1;
          if (state_q == S_SAVE_NEW && full) begin
            load_temp = 1'b1;
            state_n   = S_SAVE_CONF;
          end else if (state_q == S_SAVE_CONF && conf_match) begin
            commit_key = 1'b1;
            state_n    = S_LOCKED;
          end else begin
            err_n   = 1'b1;
            state_n = S_LOCKED;
          end
        end else if (is_star) begin
          clr_entry = 1'b1;
          err_n     = 1'b1;
          state_n   = S_LOCKED;
        end
      end
      S_LOCKOUT: begin
        if (tmr_zero) begin
          state_n  = S_LOCKED;
          fail_clr = 1'b1;
        end
      end
      default: state_n = S_LOCKED;
    endcase
  end

  // Entry buffer, key storage, failure counter, timer and error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q  <= DEFAULT_KEY;
      temp_q <= '0;
      buf_q  <= '0;
      cnt_q  <= '0;
      fail_q <= '0;
      tmr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (clr_entry) begin
        buf_q <= '0;
        cnt_q <= '0;
      end else if (shift_digit) begin
        buf_q <= {buf_q[KW-5:0], Code_1};
        if (cnt_q != CNT_OVF) cnt_q <= cnt_q + 4'd1;
      end
      if (load_temp)  temp_q <= buf_q;
      if (commit_key) key_q  <= temp_q;
      if (fail_clr)                          fail_q <= '0;
      else if (fail_inc && fail_q != FAIL_MAX) fail_q <= fail_q + 4'd1;
      if (tmr_ld)         tmr_q <= tmr_val;
      else if (!tmr_zero) tmr_q <= tmr_q - TW'(1);
      err_q <= err_n;
    end
  end

  // Output decode from registered state
  always_comb begin
    OPEN       = (state_q == S_OPEN);
    LOCK       = (state_q != S_OPEN);
    SAVE_LIGHT = (state_q == S_SAVE_NEW) || (state_q == S_SAVE_CONF);
    ALARM      = (state_q == S_LOCKOUT);
    ERR        = err_q;
    fail_cnt   = fail_q;
    count_1    = cnt_q;
  end

endmodule

// File: tb/tb_decider_param.sv
// tb/tb_decider_param.sv - self-checking bench for decider_param
module tb_decider_param;

  localparam int N           = 4;
  localparam int MAX_FAIL    = 3;
  localparam int OPEN_CYC    = 500;
  localparam int LOCKOUT_CYC = 1000;
  localparam int TIMEOUT_CYC = 2000;
  localparam int RESET_VEC   = 1 << 11;

  localparam int M_LOCKED = 0, M_OPEN = 1, M_SNEW = 2, M_SCONF = 3, M_LOCKOUT = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] code = 4'd0;
  logic       valid = 1'b0;
  logic       OPEN, LOCK, SAVE_LIGHT, ALARM, ERR;
  logic [3:0] fail_cnt, count_1;

  decider_param #(
    .N_DIGITS(N), .DEFAULT_KEY(16'h1234), .MAX_FAIL(MAX_FAIL),
    .OPEN_CYC(OPEN_CYC), .LOCKOUT_CYC(LOCKOUT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .Code_1(code), .Valid_1(valid),
    .OPEN(OPEN), .LOCK(LOCK), .SAVE_LIGHT(SAVE_LIGHT), .ALARM(ALARM), .ERR(ERR),
    .fail_cnt(fail_cnt), .count_1(count_1)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: entry kept as a queue of digits, timers as absolute deadlines
  int m_state, m_key, m_temp, m_fail, m_open_end, m_lock_end, m_last_act;
  int k = 0;
  bit m_err;
  int q[$];

  function automatic int q_val();
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  function automatic int m_vec();
    int o = (m_state == M_OPEN) ? 1 : 0;
    int s = (m_state == M_SNEW || m_state == M_SCONF) ? 1 : 0;
    int a = (m_state == M_LOCKOUT) ? 1 : 0;
    return (o << 12) | ((1 - o) << 11) | (s << 10) | (a << 9) | (int'(m_err) << 8)
           | (m_fail << 4) | q.size();
  endfunction

  function automatic int dut_vec();
    return int'({OPEN, LOCK, SAVE_LIGHT, ALARM, ERR, fail_cnt, count_1});
  endfunction

  function automatic void model_reset();
    m_state = M_LOCKED; m_key = 'h1234; m_temp = 0; m_fail = 0; m_err = 0;
    q.delete();
    m_last_act = k - 1;
  endfunction

  function automatic void model_step(input bit v, input int c);
    bit hash, star, dig, in_set, idle_exp;
    hash = v && (c == 11);
    star = v && (c == 10);
    dig  = v && (c <= 9);
    in_set = (m_state == M_LOCKED) || (m_state == M_SNEW) || (m_state == M_SCONF);
    idle_exp = 1'b0;
`ifdef DECIDER_IDLE_TIMEOUT_EN
    idle_exp = in_set && !v && (k - m_last_act == TIMEOUT_CYC);
    if (!in_set || v || idle_exp) m_last_act = k;
`endif
    m_err = 0;
    case (m_state)
      M_LOCKED: begin
        if (idle_exp) q.delete();
        else if (dig) begin
          if (q.size() <= N) q.push_back(c);
        end else if (hash || star) begin
          bit ok;
          ok = (q.size() == N) && (q_val() == m_key);
          q.delete();
          if (ok) begin
            if (hash) begin m_state = M_OPEN; m_fail = 0; m_open_end = k + OPEN_CYC; end
            else m_state = M_SNEW;
          end else begin
            m_err = 1; m_fail++;
            if (m_fail >= MAX_FAIL) begin m_state = M_LOCKOUT; m_lock_end = k + LOCKOUT_CYC; end
          end
        end
      end
      M_OPEN: begin
        if (k == m_open_end) m_state = M_LOCKED;
        else if (hash) m_open_end = k + OPEN_CYC;
        else if (star) m_state = M_LOCKED;
      end
      M_SNEW, M_SCONF: begin
        if (idle_exp) begin q.delete(); m_err = 1; m_state = M_LOCKED; end
        else if (dig) begin
          if (q.size() <= N) q.push_back(c);
        end else if (hash) begin
          if (m_state == M_SNEW && q.size() == N) begin m_temp = q_val(); m_state = M_SCONF; end
          else if (m_state == M_SCONF && q.size() == N && q_val() == m_temp) begin
            m_key = m_temp; m_state = M_LOCKED;
          end else begin m_err = 1; m_state = M_LOCKED; end
          q.delete();
        end else if (star) begin q.delete(); m_err = 1; m_state = M_LOCKED; end
      end
      M_LOCKOUT: if (k == m_lock_end) begin m_state = M_LOCKED; m_fail = 0; end
      default: m_state = M_LOCKED;
    endcase
    k++;
  endfunction

  task automatic tick(input logic v, input logic [3:0] c);
    valid = v;
    code  = c;
    @(posedge clk);
    model_step(v, int'(c));
    #1;
    check("model", dut_vec(), m_vec());
  endtask

  task automatic press(input string s);
    byte ch;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      if (ch == "#")      tick(1'b1, 4'hB);
      else if (ch == "*") tick(1'b1, 4'hA);
      else                tick(1'b1, 4'(ch - 8'h30));
    end
    valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid = 1'b0;
    #1;
    check("reset_vec", dut_vec(), RESET_VEC);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       e_open;
    logic       e_err;
    logic [3:0] e_fail;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [3:0] c, input logic o,
                              input logic e, input logic [3:0] f, input logic [3:0] n);
    vec_t r;
    r.v = v; r.c = c; r.e_open = o; r.e_err = e; r.e_fail = f; r.e_cnt = n;
    tbl.push_back(r);
  endfunction

  initial begin
    int cnt;
    int seq[$];
    int r;

    add(1, 4'd1, 0, 0, 0, 1); add(1, 4'd2, 0, 0, 0, 2);
    add(1, 4'd3, 0, 0, 0, 3); add(1, 4'd5, 0, 0, 0, 4);
    add(1, 4'hB, 0, 1, 1, 0); add(0, 4'd0, 0, 0, 1, 0);
    add(1, 4'd1, 0, 0, 1, 1); add(1, 4'd2, 0, 0, 1, 2);
    add(1, 4'd3, 0, 0, 1, 3); add(1, 4'd4, 0, 0, 1, 4);
    add(1, 4'd5, 0, 0, 1, 5); add(1, 4'd6, 0, 0, 1, 5);
    add(1, 4'hB, 0, 1, 2, 0); add(1, 4'hF, 0, 0, 2, 0);
    add(1, 4'd1, 0, 0, 2, 1); add(1, 4'd2, 0, 0, 2, 2);
    add(1, 4'd3, 0, 0, 2, 3); add(1, 4'd4, 0, 0, 2, 4);
    add(1, 4'hB, 1, 0, 0, 0); add(1, 4'd7, 1, 0, 0, 0);
    add(1, 4'hA, 0, 0, 0, 0);

    #3;
    do_reset();
    foreach (tbl[i]) begin
      tick(tbl[i].v, tbl[i].c);
      check($sformatf("tbl%0d_open", i), int'(OPEN), int'(tbl[i].e_open));
      check($sformatf("tbl%0d_err", i), int'(ERR), int'(tbl[i].e_err));
      check($sformatf("tbl%0d_fail", i), int'(fail_cnt), int'(tbl[i].e_fail));
      check($sformatf("tbl%0d_cnt", i), int'(count_1), int'(tbl[i].e_cnt));
    end
    valid = 1'b0;

    // Open then auto relock after OPEN_CYC cycles
    do_reset();
    press("1234#");
    check("t1_open", int'(OPEN), 1);
    check("t1_lock", int'(LOCK), 0);
    cnt = 0;
    while (OPEN && cnt < 600) begin cnt++; tick(1'b0, 4'd0); end
    check("t1_open_cycles", cnt, OPEN_CYC);

    // Three failures lead to lockout; keys ignored while it lasts
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      press("1235#");
      check($sformatf("t2_err%0d", i), int'(ERR), 1);
      check($sformatf("t2_fail%0d", i), int'(fail_cnt), i);
    end
    check("t2_alarm", int'(ALARM), 1);
    cnt = 0;
    while (ALARM && cnt < 1100) begin
      cnt++;
      tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    valid = 1'b0;
    check("t2_lockout_cycles", cnt, LOCKOUT_CYC);
    check("t2_fail_clr", int'(fail_cnt), 0);

    // Key change with confirmation
    do_reset();
    press("1234*");
    check("t3_save_new", int'(SAVE_LIGHT), 1);
    press("9876#");
    check("t3_save_conf", int'(SAVE_LIGHT), 1);
    press("9876#");
    check("t3_save_done", int'(SAVE_LIGHT), 0);
    check("t3_no_err", int'(ERR), 0);
    press("9876#");
    check("t3_new_open", int'(OPEN), 1);
    press("*");
    check("t3_star_lock", int'(LOCK), 1);
    press("1234#");
    check("t3_old_err", int'(ERR), 1);

    // Confirm mismatch keeps the old key; overflow entry fails
    do_reset();
    press("1234*9876#9877#");
    check("t4_conf_err", int'(ERR), 1);
    check("t4_conf_fail", int'(fail_cnt), 0);
    press("1234#");
    check("t4_old_open", int'(OPEN), 1);
    press("*");
    press("12345#");
    check("t4_ovf_err", int'(ERR), 1);

    // '#' while open reloads the timer
    do_reset();
    press("1234#");
    repeat (399) tick(1'b0, 4'd0);
    press("#");
    cnt = 0;
    while (OPEN && cnt < 600) begin cnt++; tick(1'b0, 4'd0); end
    check("t5_reload_cycles", cnt, OPEN_CYC);

    // Reset in the middle of a save restores the default key
    do_reset();
    press("1234*9876#98");
    check("t6_in_save", int'(SAVE_LIGHT), 1);
    do_reset();
    press("9876#");
    check("t6_new_rejected", int'(ERR), 1);
    press("1234#");
    check("t6_default_open", int'(OPEN), 1);

`ifdef DECIDER_IDLE_TIMEOUT_EN
    do_reset();
    press("12");
    repeat (TIMEOUT_CYC - 1) tick(1'b0, 4'd0);
    check("t6_idle_hold", int'(count_1), 2);
    tick(1'b0, 4'd0);
    check("t6_idle_clr", int'(count_1), 0);
`endif

    // Randomised sessions against the model
    do_reset();
    for (int a = 0; a < 400 && k < 30000; a++) begin
      seq.delete();
      r = $urandom_range(0, 9);
      if (r < 4) begin
        for (int d = 0; d < N; d++) seq.push_back((m_key >> (4 * (N - 1 - d))) & 15);
        seq.push_back($urandom_range(0, 1) ? 11 : 10);
      end else if (r < 8) begin
        int len = $urandom_range(1, 6);
        for (int d = 0; d < len; d++) seq.push_back($urandom_range(0, 9));
        seq.push_back($urandom_range(0, 1) ? 11 : 10);
      end else if (r == 8) begin
        for (int d = 0; d < 3; d++) seq.push_back($urandom_range(0, 15));
      end else begin
        int nk[$];
        for (int d = 0; d < N; d++) seq.push_back((m_key >> (4 * (N - 1 - d))) & 15);
        seq.push_back(10);
        for (int d = 0; d < N; d++) nk.push_back($urandom_range(0, 9));
        seq = {seq, nk, 11, nk, 11};
      end
      foreach (seq[j]) begin
        tick(1'b1, 4'(seq[j]));
        repeat ($urandom_range(0, 2)) tick(1'b0, 4'd0);
      end
    end
    valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
